// File: rtl/case_grad.sv
// case_grad: registered atan(2^-i) lookup ROM feeding the CORDIC angle
// accumulator. Output is a signed Q6.12 word (sign, 6 integer bits, 12
// fraction bits), one cycle after value/neg are sampled.
// Build option: define CASE_GRAD_RAD_EN to select the radian table;
// otherwise the table holds degrees.
module case_grad (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  value,
  input  logic        neg,
  output logic [18:0] result
);

  // Format is fixed; these are not meant to be overridden.
  localparam int FRAC_BITS = 12;
  localparam int ANGLE_W   = 1 + 6 + FRAC_BITS;

  logic [ANGLE_W-1:0] tbl_d;
  logic [ANGLE_W-1:0] result_d;
  logic [ANGLE_W-1:0] result_q;

`ifdef CASE_GRAD_RAD_EN
  // Radian table: atan(2^-i) * 4096, round-to-nearest, ties up.
  always_comb begin
    tbl_d = '0;
    case (value)
      4'd0:  tbl_d = 19'd3217;
      4'd1:  tbl_d = 19'd1899;
      4'd2:  tbl_d = 19'd1003;
      4'd3:  tbl_d = 19'd509;
      4'd4:  tbl_d = 19'd256;
      4'd5:  tbl_d = 19'd128;
      4'd6:  tbl_d = 19'd64;
      4'd7:  tbl_d = 19'd32;
      4'd8:  tbl_d = 19'd16;
      4'd9:  tbl_d = 19'd8;
      4'd10: tbl_d = 19'd4;
      4'd11: tbl_d = 19'd2;
      4'd12: tbl_d = 19'd1;
      4'd13: tbl_d = 19'd1;
      4'd14: tbl_d = 19'd0;
      4'd15: tbl_d = 19'd0;
      default: tbl_d = '0;
    endcase
  end
`else
  // Degree table: atan(2^-i) in degrees * 4096, round-to-nearest, ties up.
  always_comb begin
    tbl_d = '0;
    case (value)
      4'd0:  tbl_d = 19'd184320;
      4'd1:  tbl_d = 19'd108810;
      4'd2:  tbl_d = 19'd57492;
      4'd3:  tbl_d = 19'd29184;
      4'd4:  tbl_d = 19'd14649;
      4'd5:  tbl_d = 19'd7331;
      4'd6:  tbl_d = 19'd3667;
      4'd7:  tbl_d = 19'd1833;
      4'd8:  tbl_d = 19'd917;
      4'd9:  tbl_d = 19'd458;
      4'd10: tbl_d = 19'd229;
      4'd11: tbl_d = 19'd115;
      4'd12: tbl_d = 19'd57;
      4'd13: tbl_d = 19'd29;
      4'd14: tbl_d = 19'd14;
      4'd15: tbl_d = 19'd7;
      default: tbl_d = '0;
    endcase
  end
`endif

  // Signed step: 19-bit two's complement; a zero entry stays zero.
  always_comb begin
    result_d = neg ? (~tbl_d + 19'd1) : tbl_d;
  end

  // Single output register; reset wins over everything.
  always_ff @(posedge clk) begin
    if (rst) result_q <= '0;
    else     result_q <= result_d;
  end

  assign result = result_q;

endmodule

// File: tb/tb_case_grad.sv
// tb_case_grad: scoreboard bench for case_grad. Expected words are pushed
// when stimulus is driven and popped one edge later when the output lands.
module tb_case_grad;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  value;
  logic        neg;
  logic [18:0] result;

  int nvec = 0;
  int nerr = 0;
  logic [18:0] sb[$];
  logic [18:0] last_exp;

  case_grad u_dut (
    .clk   (clk),
    .rst   (rst),
    .value (value),
    .neg   (neg),
    .result(result)
  );

  always #5 clk = ~clk;

  function automatic logic [18:0] tbl(input logic [3:0] v);
    logic [18:0] t [16];
`ifdef CASE_GRAD_RAD_EN
    t = '{19'd3217, 19'd1899, 19'd1003, 19'd509, 19'd256, 19'd128, 19'd64, 19'd32,
          19'd16, 19'd8, 19'd4, 19'd2, 19'd1, 19'd1, 19'd0, 19'd0};
`else
    t = '{19'd184320, 19'd108810, 19'd57492, 19'd29184, 19'd14649, 19'd7331, 19'd3667, 19'd1833,
          19'd917, 19'd458, 19'd229, 19'd115, 19'd57, 19'd29, 19'd14, 19'd7};
`endif
    return t[v];
  endfunction

  function automatic logic [18:0] model(input logic [3:0] v, input logic n, input logic r);
    logic [19:0] full;
    if (r) return '0;
    full = n ? (20'd524288 - {1'b0, tbl(v)}) : {1'b0, tbl(v)};
    return full[18:0];
  endfunction

  task automatic chk(input string tag, input logic [18:0] obs, input logic [18:0] exp);
    nvec++;
    if (obs !== exp) begin
      nerr++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Drive one vector, let one edge pass, compare against the queued word.
  task automatic step(input logic [3:0] v, input logic n, input logic r, input string tag);
    @(negedge clk);
    value = v; neg = n; rst = r;
    sb.push_back(model(v, n, r));
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      nvec++; nerr++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      last_exp = sb.pop_front();
      chk(tag, result, last_exp);
    end
  endtask

  initial begin
    rst = 1'b1; value = 4'd3; neg = 1'b0;

    // Reset held for two edges with value=3, then release.
    step(4'd3, 1'b0, 1'b1, "rst0");
    step(4'd3, 1'b0, 1'b1, "rst1");
    step(4'd3, 1'b0, 1'b0, "rel");
`ifndef CASE_GRAD_RAD_EN
    chk("rel_abs", result, 19'd29184);
`endif

    // Full sweep, neg=0.
    for (int i = 0; i < 16; i++) step(4'(i), 1'b0, 1'b0, $sformatf("sweep%0d", i));

    // Downstream subtract of 10.0 deg, held over 6 cycles.
    for (int i = 0; i < 6; i++) begin
      step(4'd1, 1'b0, 1'b0, "hold");
      chk($sformatf("sub%0d", i), result - 19'd40960, model(4'd1, 1'b0, 1'b0) - 19'd40960);
    end
`ifndef CASE_GRAD_RAD_EN
    chk("sub_abs", result - 19'd40960, 19'd67850);
`endif

    // Negation.
    step(4'd0, 1'b1, 1'b0, "neg0");
`ifndef CASE_GRAD_RAD_EN
    chk("neg0_abs", result, 19'd339968);
`endif
    step(4'd15, 1'b1, 1'b0, "neg15");
`ifndef CASE_GRAD_RAD_EN
    chk("neg15_abs", result, 19'd524281);
`endif
    for (int i = 0; i < 16; i++) step(4'(i), 1'b1, 1'b0, $sformatf("nsweep%0d", i));

    // Inputs moving between edges must not disturb the held output.
    step(4'd5, 1'b0, 1'b0, "pre_glitch");
    value = 4'd9; neg = 1'b1;
    #3;
    chk("glitch", result, last_exp);

    // Back-to-back 2/4 with a one-edge reset in the middle.
    for (int i = 0; i < 8; i++) step((i % 2) ? 4'd4 : 4'd2, 1'b0, 1'b0, $sformatf("alt%0d", i));
    step(4'd2, 1'b0, 1'b1, "midrst");
    for (int i = 0; i < 4; i++) step((i % 2) ? 4'd2 : 4'd4, 1'b0, 1'b0, $sformatf("resume%0d", i));

`ifdef CASE_GRAD_RAD_EN
    step(4'd0, 1'b0, 1'b0, "rad0");
    chk("rad0_abs", result, 19'd3217);
    step(4'd13, 1'b0, 1'b0, "rad13");
    chk("rad13_abs", result, 19'd1);
    step(4'd14, 1'b1, 1'b0, "rad14n");
    chk("rad14n_abs", result, 19'd0);
`endif

    // Random mix including occasional reset.
    for (int i = 0; i < 40; i++)
      step(4'($urandom_range(15)), 1'($urandom_range(1)), ($urandom_range(9) == 0), "rand");

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
